// File: rtl/div_unit.sv
// Multicycle restoring divider for two's-complement operands; truncates toward zero.
// Build option: define DIV_REMAINDER_EN to add the signed data_remainder output.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_quo_q;
  logic             divzero_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;
  logic             busy_q;
`ifdef DIV_REMAINDER_EN
  logic             sign_rem_q;
  logic [WIDTH-1:0] remainder_q;
  logic [WIDTH-1:0] rem_signed_d;
`endif

  logic [WIDTH-1:0] abs_a_d;
  logic [WIDTH-1:0] abs_b_d;
  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quo_signed_d;
  logic             last_iter_d;

  // An unsigned WIDTH-bit magnitude holds |-2^(WIDTH-1)| exactly.
  always_comb begin
    abs_a_d = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    abs_b_d = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
  end

  // One restoring step: the borrow bit of the WIDTH+1 bit trial steers rem and the new quotient bit.
  always_comb begin
    shifted_d    = {rem_q, quo_q[WIDTH-1]};
    trial_d      = shifted_d - {1'b0, divisor_q};
    rem_d        = trial_d[WIDTH] ? shifted_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
    quo_d        = {quo_q[WIDTH-2:0], ~trial_d[WIDTH]};
    quo_signed_d = sign_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
    last_iter_d  = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef DIV_REMAINDER_EN
  always_comb begin
    rem_signed_d = sign_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      divisor_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      sign_quo_q  <= 1'b0;
      divzero_q   <= 1'b0;
      result_q    <= '0;
      exc_q       <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_rem_q  <= 1'b0;
      remainder_q <= '0;
`endif
    end else begin
      rdy_q <= 1'b0;
      if (ctrl_DIV) begin
        // A start in any state restarts; an aborted operation never reports.
        state_q    <= RUN;
        divisor_q  <= abs_b_d;
        quo_q      <= abs_a_d;
        rem_q      <= '0;
        cnt_q      <= '0;
        sign_quo_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        divzero_q  <= (data_operandB == '0);
        busy_q     <= 1'b1;
`ifdef DIV_REMAINDER_EN
        sign_rem_q <= data_operandA[WIDTH-1];
`endif
      end else begin
        unique case (state_q)
          IDLE: begin
            busy_q <= 1'b0;
          end
          RUN: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
            if (last_iter_d) begin
              state_q <= DONE;
            end
          end
          DONE: begin
            result_q <= divzero_q ? '0 : quo_signed_d;
            exc_q    <= divzero_q;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
`ifdef DIV_REMAINDER_EN
            remainder_q <= divzero_q ? '0 : rem_signed_d;
`endif
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign data_busy      = busy_q;
`ifdef DIV_REMAINDER_EN
  assign data_remainder = remainder_q;
`endif

endmodule
